// File: rtl/anode_scanner.sv
// anode_scanner: rotates an active-low one-hot digit select across the enabled digits.
// Latency: every output is registered and coherent with the Count/Index update on the same edge.
// Backpressure: none; Enable=0 freezes the scan and blanks the anodes.
// Optional feature: define SCAN_BLANK_EN to blank all anodes for BLANK_CYCLES at the start of each slot.
module anode_scanner #(
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Enable,
  input  logic [3:0] DigitMask,
  output logic [3:0] Select,
  output logic [1:0] DigitIndex,
  output logic       Blank,
  output logic       ScanTick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

`ifdef SCAN_BLANK_EN
  localparam bit BLANK_ON = 1'b1;
`else
  localparam bit BLANK_ON = 1'b0;
`endif

  // Blanking length is only meaningful when the feature is compiled in.
  localparam int BLANK_LEN = BLANK_ON ? BLANK_CYCLES : 0;
  localparam logic [CW-1:0] BLANK_LIM = CW'(BLANK_LEN);

  logic [CW-1:0] count;
  logic [1:0]    index;

  logic [CW-1:0] count_nxt;
  logic [1:0]    index_nxt;
  logic [1:0]    next_en;
  logic [1:0]    cand;
  logic          wrap;
  logic          in_blank;
  logic          drive;
  logic [3:0]    sel_nxt;
  logic          tick_nxt;

  // Next enabled digit: scan Index+4 down to Index+1 so the nearest enabled one wins;
  // with an empty mask the current index is kept.
  always_comb begin
    next_en = index;
    cand    = index;
    for (int k = 4; k >= 1; k--) begin
      cand = index + 2'(k);
      if (DigitMask[cand]) begin
        next_en = cand;
      end
    end
  end

  // Prescaler and rotation step; both hold while Enable is low.
  always_comb begin
    wrap      = (count == LAST);
    count_nxt = count;
    index_nxt = index;
    if (Enable) begin
      if (wrap) begin
        count_nxt = '0;
        index_nxt = next_en;
      end else begin
        count_nxt = count + 1'b1;
      end
    end
  end

  // Output decode from the post-edge state, so outputs and state move together.
  always_comb begin
    in_blank = BLANK_ON && (count_nxt < BLANK_LIM);
    drive    = Enable && DigitMask[index_nxt] && !in_blank;
    sel_nxt  = drive ? ~(4'b0001 << index_nxt) : 4'b1111;
    tick_nxt = Enable && (count_nxt == LAST);
  end

  // State and output registers; reset forces all anodes off.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      count    <= '0;
      index    <= '0;
      Select   <= 4'b1111;
      Blank    <= 1'b1;
      ScanTick <= 1'b0;
    end else begin
      count    <= count_nxt;
      index    <= index_nxt;
      Select   <= sel_nxt;
      Blank    <= !drive;
      ScanTick <= tick_nxt;
    end
  end

  // Index is itself a register, so the exported index is registered too.
  assign DigitIndex = index;

endmodule

// File: tb/tb_anode_scanner.sv
// tb_anode_scanner: random and directed stimulus checked against a slot-level reference model.
// Latency: outputs compared half a cycle after each active edge.
// Backpressure: not applicable.
module tb_anode_scanner;

  localparam int P = 5;
  localparam int B = 2;

`ifdef SCAN_BLANK_EN
  localparam bit BLANK_ON = 1'b1;
`else
  localparam bit BLANK_ON = 1'b0;
`endif

  logic       Clock = 1'b0;
  logic       Reset;
  logic       Enable;
  logic [3:0] DigitMask;
  logic [3:0] Select;
  logic [1:0] DigitIndex;
  logic       Blank;
  logic       ScanTick;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int m_count;
  int m_index;
  logic [3:0] e_sel;
  logic       e_blank;
  logic       e_tick;

  anode_scanner #(.PRESCALE(P), .BLANK_CYCLES(B)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Enable     (Enable),
    .DigitMask  (DigitMask),
    .Select     (Select),
    .DigitIndex (DigitIndex),
    .Blank      (Blank),
    .ScanTick   (ScanTick)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Advance the model by one edge using the slot rules directly.
  task automatic model_edge(input logic rst, input logic en, input logic [3:0] mask);
    logic active;
    if (rst) begin
      m_count = 0;
      m_index = 0;
      e_sel   = 4'b1111;
      e_blank = 1'b1;
      e_tick  = 1'b0;
      return;
    end
    if (en) begin
      if (m_count == P - 1) begin
        m_count = 0;
        for (int k = 1; k <= 4; k++) begin
          if (mask[(m_index + k) % 4]) begin
            m_index = (m_index + k) % 4;
            break;
          end
        end
      end else begin
        m_count = m_count + 1;
      end
    end
    active  = en && mask[m_index] && !(BLANK_ON && m_count < B);
    e_sel   = active ? (4'b1111 ^ (4'b0001 << m_index)) : 4'b1111;
    e_blank = !active;
    e_tick  = en && (m_count == P - 1);
  endtask

  task automatic step(input logic rst, input logic en, input logic [3:0] mask);
    Reset     = rst;
    Enable    = en;
    DigitMask = mask;
    @(posedge Clock);
    model_edge(rst, en, mask);
    @(negedge Clock);
    check("select", {28'd0, Select}, {28'd0, e_sel});
    check("blank", {31'd0, Blank}, {31'd0, e_blank});
    check("scantick", {31'd0, ScanTick}, {31'd0, e_tick});
    check("digitindex", {30'd0, DigitIndex}, m_index[31:0]);
    check("onecold", {31'd0, ($countones(~Select) <= 1)}, 32'd1);
  endtask

  initial begin
    logic [3:0] mask;
    logic       en;
    logic       rst;
    m_count = 0;
    m_index = 0;
    e_sel   = 4'b1111;
    e_blank = 1'b1;
    e_tick  = 1'b0;
    Reset = 1'b1; Enable = 1'b0; DigitMask = 4'b0000;
    @(negedge Clock);

    // reset state
    step(1'b1, 1'b1, 4'b1111);
    step(1'b1, 1'b1, 4'b1111);
    check("reset_select", {28'd0, Select}, 32'hF);
    check("reset_blank", {31'd0, Blank}, 32'd1);

    // full rotation, all digits enabled
    for (int i = 0; i < 4 * P + 3; i++) step(1'b0, 1'b1, 4'b1111);

    // sparse mask, then empty mask, then single digit
    for (int i = 0; i < 4 * P; i++) step(1'b0, 1'b1, 4'b1010);
    for (int i = 0; i < 3 * P; i++) step(1'b0, 1'b1, 4'b0000);
    check("empty_mask_select", {28'd0, Select}, 32'hF);
    for (int i = 0; i < 3 * P; i++) step(1'b0, 1'b1, 4'b0100);

    // freeze mid-slot and resume
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 4'b1111);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 4'b1111);
    check("frozen_select", {28'd0, Select}, 32'hF);
    for (int i = 0; i < 2 * P; i++) step(1'b0, 1'b1, 4'b1111);

    // reset in the middle of a slot, then restart
    step(1'b1, 1'b1, 4'b1111);
    check("midreset_index", {30'd0, DigitIndex}, 32'd0);
    for (int i = 0; i < 2 * P; i++) step(1'b0, 1'b1, 4'b1111);

    // randomized traffic
    mask = 4'b1111;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) mask = 4'($urandom_range(0, 15));
      en  = ($urandom_range(0, 7) != 0);
      rst = ($urandom_range(0, 49) == 0);
      step(rst, en, mask);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
